// File: rtl/sram_bank_pkg.sv
// sram_bank_pkg: shared FSM states and sizing helpers for the SRAM bank.
package sram_bank_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  function automatic int be_w(int data_w);
    return data_w / 8;
  endfunction
  function automatic int ptr_w(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sram_rsp_pipe.sv
// sram_rsp_pipe: RD_LAT-deep shift register carrying responses in request order.
module sram_rsp_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata
);
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;
  rsp_t stage [RD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: in_valid, err: in_err, rdata: in_rdata};
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end
  assign {rsp_valid, rsp_err, rsp_rdata} = stage[RD_LAT-1];
endmodule

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: single-port SRAM bank with byte enables, range check and zeroing clear sequencer.
module sram_bank_ctrl
  import sram_bank_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [be_w(DATA_W)-1:0]  req_be,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     init_busy
);
  localparam int BE_W  = be_w(DATA_W);
  localparam int PTR_W = ptr_w(DEPTH);
  state_t state, state_nx;
  logic [PTR_W-1:0]  clr_ptr;
  logic [PTR_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic acc, in_range, last;
  // Compare one bit wider so DEPTH == 2**ADDR_W still fits; never truncate the address.
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = req_addr[PTR_W-1:0];
  assign last     = clr_ptr == PTR_W'(DEPTH - 1);
  assign acc      = req_valid && req_ready;
  assign rd_data  = (acc && !req_we && in_range) ? mem[idx] : '0;
  always_comb begin
    state_nx  = (state == ST_CLEAR && last) ? ST_READY : state;
    req_ready = state == ST_READY;
    init_busy = state == ST_CLEAR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end
  // The array has no reset; the clear sequencer owns it until ST_READY.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_ptr] <= '0;
    else if (acc && req_we && in_range)
      for (int i = 0; i < BE_W; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
  sram_rsp_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc),
    .in_err   (acc && !in_range),
    .in_rdata (rd_data),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata)
  );
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: directed bench driving an RD_LAT=1 and an RD_LAT=3 bank with identical requests.
module tb_sram_bank_ctrl;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [15:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        rdy1, v1, e1, b1, rdy3, v3, e3, b3;
  logic [31:0] d1, d3;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(v1),
    .rsp_rdata(d1), .rsp_err(e1), .init_busy(b1));
  sram_bank_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(v3),
    .rsp_rdata(d3), .rsp_err(e3), .init_busy(b3));

  // Present one request for one cycle; on return the RD_LAT=1 response is visible.
  task automatic drive(input logic we, input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 0; req_we = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (rdy1 !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy1); else pass_cnt++;
    total++; if (v1 !== 1'b0 || v3 !== 1'b0) $display("FAIL reset_valid: got %b/%b want 0/0", v1, v3); else pass_cnt++;
    total++; if (d1 !== 32'h0 || e1 !== 1'b0) $display("FAIL reset_rdata_err: got %h/%b want 0/0", d1, e1); else pass_cnt++;
    total++; if (b1 !== 1'b1 || b3 !== 1'b1) $display("FAIL reset_busy: got %b/%b want 1/1", b1, b3); else pass_cnt++;
  endtask

  // Called on the negedge where rst_n is released; counts busy cycles and watches for stray responses.
  task automatic test_init(input string tag);
    int n = 0;
    logic seen = 0;
    while (b1 && n < 300) begin
      n++;
      seen |= v1 | v3 | rdy1;
      @(negedge clk);
    end
    total++; if (n != 256) $display("FAIL %s_busy_cycles: got %0d want 256", tag, n); else pass_cnt++;
    total++; if (seen !== 1'b0) $display("FAIL %s_quiet_during_clear: got %b want 0", tag, seen); else pass_cnt++;
    total++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || b3 !== 1'b0) $display("FAIL %s_ready: got rdy %b/%b busy3 %b want 1/1/0", tag, rdy1, rdy3, b3); else pass_cnt++;
  endtask

  task automatic test_read_ff();
    drive(0, 16'h00FF, 0, 0);
    total++; if (v1 !== 1'b1 || d1 !== 32'h0 || e1 !== 1'b0) $display("FAIL read_ff: got v%b d%h e%b want v1 d0 e0", v1, d1, e1); else pass_cnt++;
    total++; if (v3 !== 1'b0) $display("FAIL read_ff_lat3_early: got %b want 0", v3); else pass_cnt++;
    idle();
    total++; if (v1 !== 1'b0 || d1 !== 32'h0) $display("FAIL idle_zero: got v%b d%h want v0 d0", v1, d1); else pass_cnt++;
    repeat (3) idle();
  endtask

  task automatic test_write_read();
    drive(1, 16'd5, 32'hDEADBEEF, 4'hF);
    total++; if (v1 !== 1'b1 || d1 !== 32'h0 || e1 !== 1'b0) $display("FAIL wr_rsp: got v%b d%h e%b want v1 d0 e0", v1, d1, e1); else pass_cnt++;
    drive(0, 16'd5, 0, 0);
    total++; if (v1 !== 1'b1 || d1 !== 32'hDEADBEEF) $display("FAIL raw_read: got v%b d%h want v1 dDEADBEEF", v1, d1); else pass_cnt++;
    idle();
    total++; if (v1 !== 1'b0) $display("FAIL single_pulse: got %b want 0", v1); else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    drive(1, 16'd5, 32'h11223344, 4'b0101);
    drive(0, 16'd5, 0, 0);
    total++; if (d1 !== 32'hDE22BE44) $display("FAIL byte_enable: got %h want DE22BE44", d1); else pass_cnt++;
    drive(1, 16'd5, 32'hFFFFFFFF, 4'b0000);
    drive(0, 16'd5, 0, 0);
    total++; if (d1 !== 32'hDE22BE44) $display("FAIL be_zero_noop: got %h want DE22BE44", d1); else pass_cnt++;
    idle();
  endtask

  task automatic test_out_of_range();
    drive(0, 16'h0100, 0, 0);
    total++; if (v1 !== 1'b1 || e1 !== 1'b1 || d1 !== 32'h0) $display("FAIL oor_read: got v%b e%b d%h want v1 e1 d0", v1, e1, d1); else pass_cnt++;
    drive(1, 16'h0100, 32'hAAAAAAAA, 4'hF);
    total++; if (v1 !== 1'b1 || e1 !== 1'b1 || d1 !== 32'h0) $display("FAIL oor_write: got v%b e%b d%h want v1 e1 d0", v1, e1, d1); else pass_cnt++;
    drive(0, 16'h0000, 0, 0);
    total++; if (d1 !== 32'h0 || e1 !== 1'b0) $display("FAIL no_alias: got d%h e%b want d0 e0", d1, e1); else pass_cnt++;
    drive(0, 16'h00FF, 0, 0);
    total++; if (e1 !== 1'b0 || d1 !== 32'h0) $display("FAIL last_in_range: got e%b d%h want e0 d0", e1, d1); else pass_cnt++;
    repeat (4) idle();
  endtask

  task automatic test_latency3();
    drive(1, 16'd1, 32'h1, 4'hF);
    drive(1, 16'd2, 32'h2, 4'hF);
    drive(1, 16'd3, 32'h3, 4'hF);
    repeat (4) idle();
    drive(0, 16'd1, 0, 0);
    drive(0, 16'd2, 0, 0);
    total++; if (v3 !== 1'b0) $display("FAIL lat3_early: got %b want 0", v3); else pass_cnt++;
    drive(0, 16'd3, 0, 0);
    total++; if (v3 !== 1'b1 || d3 !== 32'h1) $display("FAIL lat3_rsp1: got v%b d%h want v1 d1", v3, d3); else pass_cnt++;
    idle();
    total++; if (v3 !== 1'b1 || d3 !== 32'h2) $display("FAIL lat3_rsp2: got v%b d%h want v1 d2", v3, d3); else pass_cnt++;
    idle();
    total++; if (v3 !== 1'b1 || d3 !== 32'h3) $display("FAIL lat3_rsp3: got v%b d%h want v1 d3", v3, d3); else pass_cnt++;
    idle();
    total++; if (v3 !== 1'b0 || d3 !== 32'h0) $display("FAIL lat3_drain: got v%b d%h want v0 d0", v3, d3); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(0, 16'd1, 0, 0);
    drive(0, 16'd2, 0, 0);
    total++; if (v1 !== 1'b1 || d1 !== 32'h2) $display("FAIL pre_reset_rsp: got v%b d%h want v1 d2", v1, d1); else pass_cnt++;
    req_valid = 0;
    #2 rst_n = 0;
    #1;
    total++; if (v1 !== 1'b0 || d1 !== 32'h0 || rdy1 !== 1'b0 || b1 !== 1'b1) $display("FAIL async_reset: got v%b d%h rdy%b busy%b want v0 d0 rdy0 busy1", v1, d1, rdy1, b1); else pass_cnt++;
    repeat (2) @(negedge clk);
    total++; if (v3 !== 1'b0) $display("FAIL reset_flush: got %b want 0", v3); else pass_cnt++;
    // Hold a read of addr 5 through the whole clear; it must wait for ST_READY.
    req_valid = 1; req_we = 0; req_addr = 16'd5;
    rst_n = 1;
    test_init("reinit");
    @(negedge clk);
    total++; if (v1 !== 1'b1 || d1 !== 32'h0) $display("FAIL cleared_addr5: got v%b d%h want v1 d0", v1, d1); else pass_cnt++;
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    total++; if (v3 !== 1'b1 || d3 !== 32'h0) $display("FAIL cleared_addr5_lat3: got v%b d%h want v1 d0", v3, d3); else pass_cnt++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1;
    test_init("init");
    test_read_ff();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_latency3();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
